// File: rtl/db_lookup.sv
// rtl/db_lookup.sv - direct-mapped flow filter table with 4-deep request FIFO; optional aging under DB_AGING_EN
module db_lookup #(
  parameter int KEY_SIZE   = 96,
  parameter int HASH_WIDTH = 10,
  parameter int AGE_SHIFT  = 20,
  parameter int AGE_LIMIT  = 16
) (
  input  logic                clk156,
  input  logic                eth_rst_n,
  input  logic [KEY_SIZE-1:0] in_key,
  input  logic [3:0]          in_flag,
  input  logic                in_valid,
  output logic                out_valid,
  output logic [3:0]          out_flag,
  output logic                init_done,
  output logic [15:0]         drop_cnt
);

  localparam int DEPTH  = 1 << HASH_WIDTH;
  localparam int NCHUNK = (KEY_SIZE + HASH_WIDTH - 1) / HASH_WIDTH;
  localparam int PADW   = NCHUNK * HASH_WIDTH;
  localparam logic [HASH_WIDTH-1:0] LAST_IDX = '1;
  localparam logic [1:0] OP_SUSPECT = 2'b01;
  localparam logic [1:0] OP_ARREST  = 2'b10;

  if (HASH_WIDTH < 1 || KEY_SIZE < HASH_WIDTH || AGE_SHIFT < 1 || AGE_LIMIT < 1 || AGE_LIMIT > 256) begin : g_bad_params
    $error("db_lookup: illegal parameter combination");
  end

  typedef enum logic {S_INIT, S_RUN} state_t;

  typedef struct packed {
    logic [KEY_SIZE-1:0] key;
    logic [1:0]          op;
  } req_t;

  // XOR-fold of the key in HASH_WIDTH-bit chunks from the LSB, top chunk zero-padded
  function automatic logic [HASH_WIDTH-1:0] key_hash(input logic [KEY_SIZE-1:0] key);
    logic [PADW-1:0]       padded;
    logic [HASH_WIDTH-1:0] acc;
    padded = '0;
    padded[KEY_SIZE-1:0] = key;
    acc = '0;
    for (int c = 0; c < NCHUNK; c++) begin
      acc = acc ^ padded[c*HASH_WIDTH +: HASH_WIDTH];
    end
    return acc;
  endfunction

  // reserved flag bit is deliberately ignored
  logic unused_flag_bit;
  assign unused_flag_bit = in_flag[3];

  state_t                state_q, state_d;
  logic [HASH_WIDTH-1:0] init_idx_q, init_idx_d;
  logic                  init_clr;
  logic                  pop;

  req_t       fifo_q [4];
  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0] count_q;
  logic [15:0] drop_cnt_q;
  logic       push_req, push, drop;
  req_t       head;
  logic [HASH_WIDTH-1:0] head_idx;

  logic [KEY_SIZE-1:0] tag_mem  [DEPTH];
  logic [1:0]          stat_mem [DEPTH];
  logic                vld_mem  [DEPTH];

  logic                  r_valid_q;
  logic [KEY_SIZE-1:0]   r_key_q;
  logic [1:0]            r_op_q;
  logic [HASH_WIDTH-1:0] r_idx_q;
  logic                  r_ent_vld_q;
  logic [KEY_SIZE-1:0]   r_ent_tag_q;
  logic [1:0]            r_ent_stat_q;

  logic       hit, age_ok, wr_en, fwd;
  logic [1:0] wr_stat;
  logic [3:0] reply;
  logic       out_valid_q;
  logic [3:0] out_flag_q;

  // FSM state and sweep index registers
  always_ff @(posedge clk156) begin
    if (!eth_rst_n) begin
      state_q    <= S_INIT;
      init_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
    end
  end

  // FSM next state: clear one valid bit per cycle, then serve the FIFO forever
  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    init_clr   = 1'b0;
    pop        = 1'b0;
    case (state_q)
      S_INIT: begin
        init_clr = 1'b1;
        if (init_idx_q == LAST_IDX) begin
          state_d = S_RUN;
        end else begin
          init_idx_d = init_idx_q + 1'b1;
        end
      end
      S_RUN: begin
        pop = (count_q != 3'd0);
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  assign init_done = (state_q == S_RUN);

  assign push_req = in_valid & in_flag[0];
  assign push     = push_req & ((count_q != 3'd4) | pop);
  assign drop     = push_req & (count_q == 3'd4) & ~pop;
  assign head     = fifo_q[rd_ptr_q];
  assign head_idx = key_hash(head.key);

  // FIFO storage; a full FIFO still accepts when the head leaves the same cycle
  always_ff @(posedge clk156) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= {in_key, in_flag[2:1]};
    end
  end

  // FIFO pointers, occupancy and saturating overflow counter
  always_ff @(posedge clk156) begin
    if (!eth_rst_n) begin
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      count_q    <= 3'd0;
      drop_cnt_q <= 16'd0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q <= count_q + {2'b00, push} - {2'b00, pop};
      if (drop && drop_cnt_q != 16'hFFFF) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  assign drop_cnt = drop_cnt_q;

`ifdef DB_AGING_EN
  localparam logic [8:0] AGE_LIM9 = 9'(AGE_LIMIT);

  logic [AGE_SHIFT-1:0] age_cnt_q;
  logic [7:0]           epoch_q;
  logic [7:0]           stamp_mem [DEPTH];
  logic [7:0]           r_ent_stamp_q;
  logic [7:0]           age;

  // free-running tick counter; epoch advances once per 2^AGE_SHIFT cycles
  always_ff @(posedge clk156) begin
    if (!eth_rst_n) begin
      age_cnt_q <= '0;
      epoch_q   <= 8'd0;
    end else begin
      age_cnt_q <= age_cnt_q + 1'b1;
      if (&age_cnt_q) epoch_q <= epoch_q + 8'd1;
    end
  end

  // stamp storage refreshed on every write or upgrade
  always_ff @(posedge clk156) begin
    if (wr_en) stamp_mem[r_idx_q] <= epoch_q;
  end

  // stamp travels with the rest of the entry through stage R, forwarded like it
  always_ff @(posedge clk156) begin
    if (pop) r_ent_stamp_q <= fwd ? epoch_q : stamp_mem[head_idx];
  end

  assign age    = epoch_q - r_ent_stamp_q;
  assign age_ok = ({1'b0, age} < AGE_LIM9);
`else
  assign age_ok = 1'b1;
`endif

  assign fwd = wr_en & (r_idx_q == head_idx);

  // Stage R: latch the popped request and its table entry, taking stage W's write on an index match
  always_ff @(posedge clk156) begin
    if (!eth_rst_n) r_valid_q <= 1'b0;
    else            r_valid_q <= pop;
    if (pop) begin
      r_key_q      <= head.key;
      r_op_q       <= head.op;
      r_idx_q      <= head_idx;
      r_ent_vld_q  <= fwd ? 1'b1    : vld_mem[head_idx];
      r_ent_tag_q  <= fwd ? r_key_q : tag_mem[head_idx];
      r_ent_stat_q <= fwd ? wr_stat : stat_mem[head_idx];
    end
  end

  // Stage W: hit test, write-back decision and verdict
  always_comb begin
    hit     = r_valid_q & r_ent_vld_q & (r_ent_tag_q == r_key_q) & age_ok;
    wr_en   = 1'b0;
    wr_stat = OP_SUSPECT;
    reply   = 4'b0000;
    case (r_op_q)
      OP_SUSPECT: begin
        if (hit) begin
          reply = {1'b0, r_ent_stat_q, 1'b1};
        end else begin
          wr_en   = r_valid_q;
          wr_stat = OP_SUSPECT;
        end
      end
      OP_ARREST: begin
        if (hit) begin
          reply = {1'b0, OP_ARREST, 1'b1};
          if (r_ent_stat_q == OP_SUSPECT) begin
            wr_en   = 1'b1;
            wr_stat = OP_ARREST;
          end
        end
      end
      default: begin
        if (hit) reply = {1'b0, r_ent_stat_q, 1'b1};
      end
    endcase
    wr_en = wr_en & eth_rst_n;
  end

  // Table write-back from stage W; the INIT sweep owns the valid bits until RUN
  always_ff @(posedge clk156) begin
    if (wr_en) begin
      tag_mem[r_idx_q]  <= r_key_q;
      stat_mem[r_idx_q] <= wr_stat;
    end
    if (init_clr) begin
      vld_mem[init_idx_q] <= 1'b0;
    end else if (wr_en) begin
      vld_mem[r_idx_q] <= 1'b1;
    end
  end

  // Verdict registers; the flag holds between strobes
  always_ff @(posedge clk156) begin
    if (!eth_rst_n) begin
      out_valid_q <= 1'b0;
      out_flag_q  <= 4'b0000;
    end else begin
      out_valid_q <= r_valid_q;
      if (r_valid_q) out_flag_q <= reply;
    end
  end

  assign out_valid = out_valid_q;
  assign out_flag  = out_flag_q;

endmodule

// File: tb/tb_db_lookup.sv
// tb/tb_db_lookup.sv - self-checking bench for db_lookup
module tb_db_lookup;
  localparam int KW = 96;
  localparam int HW = 10;

  logic          clk156 = 1'b0;
  logic          eth_rst_n;
  logic [KW-1:0] in_key;
  logic [3:0]    in_flag;
  logic          in_valid;
  logic          out_valid;
  logic [3:0]    out_flag;
  logic          init_done;
  logic [15:0]   drop_cnt;

  always #5 clk156 = ~clk156;

  db_lookup #(.KEY_SIZE(KW), .HASH_WIDTH(HW), .AGE_SHIFT(4), .AGE_LIMIT(2)) dut (
    .clk156(clk156), .eth_rst_n(eth_rst_n), .in_key(in_key), .in_flag(in_flag),
    .in_valid(in_valid), .out_valid(out_valid), .out_flag(out_flag),
    .init_done(init_done), .drop_cnt(drop_cnt)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit mon_model_en = 1'b1;
  logic [3:0] last_flag = 4'b0000;

  typedef struct { int c; logic [3:0] f; } rep_t;
  rep_t       rep_q[$];
  logic [3:0] exp_q[$];

  typedef struct {
    logic [KW-1:0] key;
    logic [3:0]    flag;
    bit            expect_reply;
    logic [3:0]    exp;
    string         name;
  } vec_t;
  vec_t vecs[$];

  // reference table: index -> {valid, key, status}
  bit            m_vld  [int];
  logic [KW-1:0] m_key  [int];
  logic [1:0]    m_stat [int];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int model_hash(input logic [KW-1:0] k);
    int h = 0;
    for (int i = 0; i < KW; i++) if (k[i]) h = h ^ (1 << (i % HW));
    return h;
  endfunction

  task automatic model_apply(input logic [KW-1:0] k, input logic [3:0] f, output logic [3:0] r);
    int h;
    bit hit;
    h = model_hash(k);
    hit = m_vld.exists(h) && (m_key[h] == k);
    r = 4'b0000;
    if (f[2:1] == 2'b01) begin
      if (hit) r = {1'b0, m_stat[h], 1'b1};
      else begin m_vld[h] = 1'b1; m_key[h] = k; m_stat[h] = 2'b01; end
    end else if (f[2:1] == 2'b10) begin
      if (hit) begin m_stat[h] = 2'b10; r = 4'b0101; end
    end else if (hit) begin
      r = {1'b0, m_stat[h], 1'b1};
    end
  endtask

  task automatic model_clear();
    m_vld.delete(); m_key.delete(); m_stat.delete(); exp_q.delete();
  endtask

  // monitor: sample after the edge, log replies, check against the model and flag hold
  always @(posedge clk156) begin
    #1;
    cyc++;
    if (!eth_rst_n) begin
      last_flag = 4'b0000;
    end else if (out_valid) begin
      rep_q.push_back('{cyc, out_flag});
      last_flag = out_flag;
      if (mon_model_en) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_reply: got flag %b, model expects no reply", out_flag);
        end else begin
          check("model_reply", out_flag, exp_q.pop_front());
        end
      end
    end else begin
      check("flag_hold", out_flag, last_flag);
    end
  end

  task automatic drive(input logic [KW-1:0] k, input logic [3:0] f, input bit v, input bit acc);
    logic [3:0] r;
    @(negedge clk156);
    in_key = k; in_flag = f; in_valid = v;
    if (acc) begin model_apply(k, f, r); exp_q.push_back(r); end
  endtask

  task automatic idle();
    @(negedge clk156);
    in_valid = 1'b0; in_flag = 4'b0000;
  endtask

  task automatic run_single(input logic [KW-1:0] k, input logic [3:0] f, input bit expect_reply,
                            input logic [3:0] exp, input string name, input bit acc);
    int d;
    rep_q.delete();
    drive(k, f, 1'b1, acc);
    d = cyc;
    idle();
    repeat (8) @(negedge clk156);
    check({name, "_count"}, rep_q.size(), expect_reply ? 1 : 0);
    if (expect_reply && rep_q.size() > 0) begin
      check({name, "_latency"}, rep_q[0].c - d, 3);
      check(name, rep_q[0].f, exp);
    end
  endtask

  task automatic add_vec(input logic [KW-1:0] k, input logic [3:0] f, input bit e, input logic [3:0] x, input string n);
    vec_t v;
    v.key = k; v.flag = f; v.expect_reply = e; v.exp = x; v.name = n;
    vecs.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [KW-1:0] ka, kb, kc, kd, ke, kf, kg, kh, kj, kx;
    logic [KW-1:0] pool [8];
    logic [3:0] f;
    bit v, ov_seen;
    int d, t_init;

    ka = 96'h0123_4567_89AB_CDEF_0011_2233;
    kb = 96'hFEDC_BA98_7654_3210_A5A5_5A5A;
    kc = ka ^ 96'h401;
    kd = 96'h1357_9BDF_2468_ACE0_F0F0_0F0F;
    ke = 96'h0000_1111_2222_3333_4444_5555;
    kf = 96'h6666_7777_8888_9999_AAAA_BBBB;
    kg = 96'hCAFE_BABE_DEAD_BEEF_0BAD_F00D;
    kh = 96'h1111_2222_3333_4444_5555_6666;
    kj = 96'h7777_0000_7777_0000_7777_0000;

    eth_rst_n = 1'b0; in_valid = 1'b0; in_key = '0; in_flag = 4'b0000;
    repeat (3) @(negedge clk156);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_flag", out_flag, 0);
    check("rst_init_done", init_done, 0);
    check("rst_drop_cnt", drop_cnt, 0);

    @(negedge clk156);
    eth_rst_n = 1'b1;
    d = cyc; t_init = -1; ov_seen = 1'b0;
    for (int k = 0; k < 1100 && t_init < 0; k++) begin
      @(negedge clk156);
      if (out_valid) ov_seen = 1'b1;
      if (init_done) t_init = cyc - d;
    end
    check("init_latency", t_init, 1024);
    check("ov_during_init", ov_seen, 0);

`ifndef DB_AGING_EN
    add_vec(ka, 4'b0011, 1, 4'b0000, "suspect_a_new");
    add_vec(ka, 4'b0101, 1, 4'b0101, "arrest_a_upgrade");
    add_vec(ka, 4'b0011, 1, 4'b0101, "suspect_a_keeps_arrest");
    add_vec(kb, 4'b0101, 1, 4'b0000, "arrest_b_miss");
    add_vec(kb, 4'b0001, 1, 4'b0000, "query_b_not_written");
    add_vec(ka, 4'b0111, 1, 4'b0101, "query11_a");
    add_vec(ka, 4'b0100, 0, 4'b0000, "disabled_req");
    add_vec(kc, 4'b0011, 1, 4'b0000, "suspect_c_collides");
    add_vec(ka, 4'b0001, 1, 4'b0000, "query_a_evicted");
    add_vec(kc, 4'b0001, 1, 4'b0011, "query_c_suspect");
    add_vec(kc, 4'b0101, 1, 4'b0101, "arrest_c");
    add_vec(kd, 4'b1011, 1, 4'b0000, "suspect_d_bit3");
    add_vec(kd, 4'b1001, 1, 4'b0011, "query_d_bit3");
    foreach (vecs[i]) begin
      run_single(vecs[i].key, vecs[i].flag, vecs[i].expect_reply, vecs[i].exp, vecs[i].name, vecs[i].flag[0]);
    end

    for (int i = 0; i < 4; i++) begin
      kx = {$urandom, $urandom, $urandom};
      pool[2*i] = kx;
      pool[2*i+1] = (i % 2 == 0) ? (kx ^ 96'h401) : (kx ^ {1'b1, 89'd0, 6'h20});
    end
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      f = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) != 0) f[0] = 1'b1;
      drive(pool[$urandom_range(0, 7)], f, v, v && f[0]);
    end
    idle();
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk156);
    check("random_drain", exp_q.size(), 0);
    check("random_no_drop", drop_cnt, 0);
`endif

    rep_q.delete();
    drive(kg, 4'b0011, 1'b1, 1'b1);
    d = cyc;
    drive(kg, 4'b0101, 1'b1, 1'b1);
    idle();
    repeat (8) @(negedge clk156);
    check("fwd_count", rep_q.size(), 2);
    if (rep_q.size() == 2) begin
      check("fwd_first", rep_q[0].f, 4'b0000);
      check("fwd_second", rep_q[1].f, 4'b0101);
      check("fwd_latency", rep_q[0].c - d, 3);
      check("fwd_consecutive", rep_q[1].c - rep_q[0].c, 1);
    end

    rep_q.delete();
    drive(ka, 4'b0011, 1'b1, 1'b0);
    idle();
    @(negedge clk156);
    eth_rst_n = 1'b0;
    model_clear();
    repeat (3) @(negedge clk156);
    check("abort_no_reply", rep_q.size(), 0);
    check("abort_init_done", init_done, 0);
    @(negedge clk156);
    eth_rst_n = 1'b1;
    drive(ke, 4'b0011, 1'b1, 1'b1);
    drive(ke, 4'b0001, 1'b1, 1'b1);
    drive(ke, 4'b0101, 1'b1, 1'b1);
    drive(ke, 4'b0111, 1'b1, 1'b1);
    drive(kf, 4'b0011, 1'b1, 1'b0);
    drive(kf, 4'b0101, 1'b1, 1'b0);
    idle();
    check("overflow_drop_cnt", drop_cnt, 2);
    check("overflow_still_init", init_done, 0);
    for (int k = 0; k < 1100 && !init_done; k++) @(negedge clk156);
    check("reinit_done", init_done, 1);
    repeat (8) @(negedge clk156);
    check("queued_count", rep_q.size(), 4);
    if (rep_q.size() == 4) begin
      check("queued_0", rep_q[0].f, 4'b0000);
      check("queued_1", rep_q[1].f, 4'b0011);
      check("queued_2", rep_q[2].f, 4'b0101);
      check("queued_3", rep_q[3].f, 4'b0101);
      check("queued_consecutive", rep_q[3].c - rep_q[0].c, 3);
    end

`ifdef DB_AGING_EN
    mon_model_en = 1'b0;
    run_single(kh, 4'b0011, 1, 4'b0000, "age_suspect_h", 1'b0);
    repeat (32) @(negedge clk156);
    run_single(kh, 4'b0101, 1, 4'b0000, "age_arrest_h_expired", 1'b0);
    run_single(kj, 4'b0011, 1, 4'b0000, "age_suspect_j", 1'b0);
    run_single(kj, 4'b0101, 1, 4'b0101, "age_arrest_j_fresh", 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
